// File: rtl/clcg_rng_scheduler.sv
// Seeds and starts the dual-CLCG RNG, drops warm-up bits, serializes WIDTH bits into a word for one of two requesters.
// Latency: 2+WARMUP+WIDTH-1 edges from grant to ack with reseed, WIDTH without; requesters hold req until their one-cycle ack.
module clcg_rng_scheduler #(
  parameter int          WIDTH    = 16,
  parameter int          WARMUP   = 8,
  parameter logic [15:0] SEED_RST = 16'h5A3C
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req,
  input  logic [15:0]      seed_in,
  input  logic             seed_load,
  input  logic             rng_bit,
  output logic             rng_start,
  output logic [3:0]       rng_x0,
  output logic [3:0]       rng_y0,
  output logic [3:0]       rng_p0,
  output logic [3:0]       rng_q0,
  output logic [1:0]       ack,
  output logic [WIDTH-1:0] rnd_word,
  output logic             busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEED,
    S_WARM,
    S_COLLECT,
    S_DONE
  } state_t;

  localparam int CNT_MAX = (WIDTH > WARMUP) ? WIDTH : WARMUP;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] WARM_LAST = CNT_W'(WARMUP - 1);
  localparam logic [CNT_W-1:0] COLL_LAST = CNT_W'(WIDTH - 1);

  state_t           state;
  state_t           state_nxt;
  logic [15:0]      seed;
  logic             reseed_pend;
  logic             last;
  logic             gnt;
  logic             gnt_pick;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shifted;
  logic             start_nxt;
  logic [1:0]       ack_nxt;

  assign rng_x0  = seed[15:12];
  assign rng_y0  = seed[11:8];
  assign rng_p0  = seed[7:4];
  assign rng_q0  = seed[3:0];
  assign shifted = {shreg[WIDTH-2:0], rng_bit};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (req != 2'b00) begin
          state_nxt = reseed_pend ? S_SEED : S_COLLECT;
        end
      end
      S_SEED: state_nxt = S_WARM;
      S_WARM: begin
        if (cnt == WARM_LAST) begin
          state_nxt = S_COLLECT;
        end
      end
      S_COLLECT: begin
        if (cnt == COLL_LAST) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // rng_start and ack are registered from the next-state decode so they never glitch
  always_comb begin
    busy      = (state != S_IDLE);
    gnt_pick  = (req == 2'b11) ? ~last : req[1];
    start_nxt = (state_nxt == S_SEED);
    ack_nxt   = 2'b00;
    if (state_nxt == S_DONE) begin
      ack_nxt = gnt ? 2'b10 : 2'b01;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rng_start <= 1'b0;
      ack       <= 2'b00;
    end else begin
      rng_start <= start_nxt;
      ack       <= ack_nxt;
    end
  end

  // A load during SEED keeps the flag set so the fresh seed is not skipped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seed        <= SEED_RST;
      reseed_pend <= 1'b1;
    end else begin
      if (seed_load) begin
        seed        <= seed_in;
        reseed_pend <= 1'b1;
      end else if (state == S_SEED) begin
        reseed_pend <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last <= 1'b1;
      gnt  <= 1'b0;
    end else if ((state == S_IDLE) && (req != 2'b00)) begin
      last <= gnt_pick;
      gnt  <= gnt_pick;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else begin
      case (state)
        S_WARM:    cnt <= (cnt == WARM_LAST) ? '0 : cnt + CNT_W'(1);
        S_COLLECT: cnt <= (cnt == COLL_LAST) ? '0 : cnt + CNT_W'(1);
        default:   cnt <= '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg    <= '0;
      rnd_word <= '0;
    end else if (state == S_COLLECT) begin
      shreg <= shifted;
      if (cnt == COLL_LAST) begin
        rnd_word <= shifted;
      end
    end
  end

endmodule

// File: tb/tb_clcg_rng_scheduler.sv
// Bench for clcg_rng_scheduler: timeline model of each transaction checked every cycle, plus directed literal checks.
module tb_clcg_rng_scheduler;
  localparam int W  = 16;
  localparam int WU = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic [1:0]   req = 2'b00;
  logic [15:0]  seed_in = 16'h0000;
  logic         seed_load = 1'b0;
  logic         rng_bit = 1'b0;
  logic         rng_start;
  logic [3:0]   rng_x0, rng_y0, rng_p0, rng_q0;
  logic [1:0]   ack;
  logic [W-1:0] rnd_word;
  logic         busy;

  int n_chk = 0;
  int n_pass = 0;
  bit chk_on = 1'b0;

  clcg_rng_scheduler #(.WIDTH(W), .WARMUP(WU), .SEED_RST(16'h5A3C)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .seed_in(seed_in), .seed_load(seed_load),
    .rng_bit(rng_bit), .rng_start(rng_start), .rng_x0(rng_x0), .rng_y0(rng_y0),
    .rng_p0(rng_p0), .rng_q0(rng_q0), .ack(ack), .rnd_word(rnd_word), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  // Model: a transaction is a timeline of edges counted from the grant edge (t=0).
  // Reseeded words sample rng_bit on edges WU+2..WU+1+W, plain words on 1..W;
  // ack is high after the last sampling edge, and the next edge returns to idle.
  bit          m_active, m_rs, m_g, m_last, m_pend;
  int          m_t;
  logic [15:0] m_seed;
  logic [W-1:0] m_word, m_acc;

  function automatic int first_edge(input bit rs);
    return rs ? WU + 2 : 1;
  endfunction

  function automatic int last_edge(input bit rs);
    return first_edge(rs) + W - 1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active <= 1'b0; m_rs <= 1'b0; m_g <= 1'b0; m_last <= 1'b1; m_pend <= 1'b1;
      m_t <= 0; m_seed <= 16'h5A3C; m_word <= '0; m_acc <= '0;
    end else begin
      if (m_active) begin
        if (m_t + 1 >= first_edge(m_rs) && m_t + 1 <= last_edge(m_rs))
          m_acc <= {m_acc[W-2:0], rng_bit};
        if (m_t + 1 == last_edge(m_rs))
          m_word <= {m_acc[W-2:0], rng_bit};
        if (m_t + 1 == last_edge(m_rs) + 1) m_active <= 1'b0;
        else m_t <= m_t + 1;
      end else if (req != 2'b00) begin
        m_g      <= (req == 2'b11) ? ~m_last : req[1];
        m_last   <= (req == 2'b11) ? ~m_last : req[1];
        m_rs     <= m_pend;
        m_active <= 1'b1;
        m_t      <= 0;
      end
      if (seed_load) begin
        m_seed <= seed_in;
        m_pend <= 1'b1;
      end else if (m_active && m_rs && m_t == 0) begin
        m_pend <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("busy", busy, m_active);
      chk("rng_start", rng_start, m_active && m_rs && m_t == 0);
      chk("ack", ack, (m_active && m_t == last_edge(m_rs)) ? (m_g ? 2'b10 : 2'b01) : 2'b00);
      chk("rnd_word", rnd_word, m_word);
      chk("seed", {rng_x0, rng_y0, rng_p0, rng_q0}, m_seed);
    end
  end

  function automatic logic bitval(input bit alt, input int e, input int k);
    if (!alt) return 1'b1;
    if (e < k) return 1'b0;
    return ((e - k) % 2) == 0;
  endfunction

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 40; i++) begin
      if (!busy) return;
      @(negedge clk); #1;
    end
    fail_now({tag, " idle"});
  endtask

  // Called at negedge+1; the first following edge is the grant edge E0.
  task automatic run_txn(input logic [1:0] r, input bit alt, input int drop_at, input int seed_at,
                         input logic [1:0] exp_ack, input int exp_lat, input logic [W-1:0] exp_word,
                         input int exp_starts, input string tag);
    int c, starts, k;
    bit got;
    k = exp_lat - W + 1;
    c = 0; starts = 0; got = 1'b0;
    req = r;
    rng_bit = bitval(alt, 0, k);
    while (c < 60 && !got) begin
      @(negedge clk);
      if (rng_start) starts++;
      if (seed_at >= 0 && c == seed_at + 1) chk({tag, " x0 after load"}, rng_x0, 4'h1);
      if (ack != 2'b00) begin
        got = 1'b1;
        chk({tag, " ack"}, ack, exp_ack);
        chk({tag, " latency"}, c, exp_lat);
        chk({tag, " word"}, rnd_word, exp_word);
        chk({tag, " starts"}, starts, exp_starts);
      end
      #1;
      seed_load = (c == seed_at);
      if (c == drop_at) req = 2'b00;
      c++;
      rng_bit = bitval(alt, c, k);
    end
    if (!got) fail_now({tag, " ack"});
    seed_load = 1'b0;
    req = 2'b00;
    wait_idle(tag);
  endtask

  logic [1:0] exp_order [4] = '{2'b01, 2'b10, 2'b01, 2'b10};

  initial begin
    int idx, cyc;
    #1 rst_n = 1'b0;
    chk_on = 1'b1;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("reset busy", busy, 1'b0);
    chk("reset rnd_word", rnd_word, 16'h0000);
    chk("reset seed", {rng_x0, rng_y0, rng_p0, rng_q0}, 16'h5A3C);
    chk("reset ack", ack, 2'b00);
    chk("reset start", rng_start, 1'b0);
    #1;

    run_txn(2'b01, 1'b1, -1, -1, 2'b01, 25, 16'hAAAA, 1, "t1 first");
    run_txn(2'b10, 1'b0, -1, -1, 2'b10, 16, 16'hFFFF, 0, "t2 noreseed");

    seed_in = 16'h1234;
    run_txn(2'b01, 1'b0, -1, 5, 2'b01, 16, 16'hFFFF, 0, "t4 loadmid");
    run_txn(2'b10, 1'b1, -1, -1, 2'b10, 25, 16'hAAAA, 1, "t4 reseed");

    run_txn(2'b01, 1'b0, 3, -1, 2'b01, 16, 16'hFFFF, 0, "t6 drop");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t6 stays idle", busy, 1'b0);
    end
    #1;

    seed_in = 16'h9E71;
    seed_load = 1'b1;
    @(negedge clk); #1 seed_load = 1'b0;
    req = 2'b10;
    repeat (5) @(negedge clk);
    chk("t5 busy in warm", busy, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    chk("t5 rst busy", busy, 1'b0);
    chk("t5 rst word", rnd_word, 16'h0000);
    chk("t5 rst ack", ack, 2'b00);
    chk("t5 rst start", rng_start, 1'b0);
    chk("t5 rst seed", {rng_x0, rng_y0, rng_p0, rng_q0}, 16'h5A3C);
    req = 2'b00;
    @(negedge clk); #1 rst_n = 1'b1;
    run_txn(2'b01, 1'b1, -1, -1, 2'b01, 25, 16'hAAAA, 1, "t5 after reset");

    rst_n = 1'b0;
    @(negedge clk); #1 rst_n = 1'b1;
    req = 2'b11;
    idx = 0; cyc = 0;
    while (idx < 4 && cyc < 300) begin
      @(negedge clk); cyc++;
      if (ack != 2'b00) begin
        chk($sformatf("t3 grant %0d", idx), ack, exp_order[idx]);
        idx++;
        @(negedge clk); cyc++;
        chk("t3 ack one cycle", ack, 2'b00);
      end
      #1 rng_bit = 1'($urandom_range(0, 1));
    end
    if (idx < 4) fail_now("t3 contention");
    req = 2'b00;
    wait_idle("t3");

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
